// File: rtl/ptp_tsu_regs_mc.sv
// ptp_tsu_regs_mc: CPU register bank for N_CH PTP TSU timestamp queues.
// Ports: clk/rst (async, active-low); wr_in/rd_in/addr_in/data_in/data_out
// CPU bus; q_rst_out/q_rd_en_out/q_msgid_mask_out to the FIFOs;
// q_empty_in/q_stat_in/q_data_in from the FIFOs; irq_out interrupt.
// Optional macro PTP_TSU_REGS_MC_IRQ_EN adds IRQEN registers and irq_out.
module ptp_tsu_regs_mc #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 128,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_in,
  input  logic                     rd_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [31:0]              data_in,
  output logic [31:0]              data_out,
  output logic [N_CH-1:0]          q_rst_out,
  output logic [N_CH-1:0]          q_rd_en_out,
  output logic [8*N_CH-1:0]        q_msgid_mask_out,
  input  logic [N_CH-1:0]          q_empty_in,
  input  logic [8*N_CH-1:0]        q_stat_in,
  input  logic [DATA_W*N_CH-1:0]   q_data_in,
  output logic                     irq_out
);

  localparam int CW = ADDR_W - 5;

  typedef enum logic {IDLE, WAIT} st_e;

  logic [CW-1:0]     ch;
  logic [2:0]        off;
  logic [N_CH-1:0]   sel;
  logic [N_CH-1:0]   ctrl;

  st_e               st_q   [N_CH];
  st_e               st_d   [N_CH];
  logic [2:0]        cnt_q  [N_CH];
  logic [2:0]        cnt_d  [N_CH];
  logic [7:0]        mask_q [N_CH];
  logic [7:0]        mask_d [N_CH];
  logic [DATA_W-1:0] cap_q  [N_CH];
  logic [DATA_W-1:0] cap_d  [N_CH];
  logic [N_CH-1:0]   done_q, done_d;
  logic [N_CH-1:0]   err_q, err_d;
  logic [N_CH-1:0]   rd_q, rd_d;
  logic [N_CH-1:0]   qr_q, qr_d;
  logic [31:0]       dout_q, rdata;
  logic [127:0]      capx;

`ifdef PTP_TSU_REGS_MC_IRQ_EN
  logic [1:0]        ien_q [N_CH];
  logic [1:0]        ien_d [N_CH];
  logic              irq_q, irq_d;
`endif

  assign ch  = addr_in[ADDR_W-1:5];
  assign off = addr_in[4:2];

  // Channels beyond N_CH never match, so they ignore writes and read 0.
  always_comb begin
    sel  = '0;
    ctrl = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel[k]  = (ch == CW'(k));
      ctrl[k] = wr_in && sel[k] && (off == 3'd0);
    end
  end

  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    rd_d   = '0;
    qr_d   = '0;
    for (int k = 0; k < N_CH; k++) begin
      st_d[k]   = st_q[k];
      cnt_d[k]  = cnt_q[k];
      mask_d[k] = mask_q[k];
      cap_d[k]  = cap_q[k];
`ifdef PTP_TSU_REGS_MC_IRQ_EN
      ien_d[k]  = ien_q[k];
      if (wr_in && sel[k] && off == 3'd2)
        ien_d[k] = data_in[1:0];
`endif
      if (wr_in && sel[k] && off == 3'd1)
        mask_d[k] = data_in[31:24];
      if (st_q[k] == WAIT) begin
        if (cnt_q[k] == 3'd0) begin
          cap_d[k]  = q_data_in[k*DATA_W +: DATA_W];
          done_d[k] = 1'b1;
          st_d[k]   = IDLE;
        end else begin
          cnt_d[k] = cnt_q[k] - 3'd1;
        end
      end
      if (ctrl[k] && data_in[2])
        err_d[k] = 1'b0;
      // QRST overrides POP and aborts any capture in flight.
      if (ctrl[k] && data_in[1]) begin
        qr_d[k]   = 1'b1;
        st_d[k]   = IDLE;
        done_d[k] = 1'b0;
        cap_d[k]  = cap_q[k];
      end else if (ctrl[k] && data_in[0]) begin
        if (st_q[k] == WAIT || q_empty_in[k]) begin
          err_d[k] = 1'b1;
        end else begin
          rd_d[k]   = 1'b1;
          st_d[k]   = WAIT;
          cnt_d[k]  = 3'(RD_LAT);
          done_d[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    capx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel[k]) begin
        capx[127 -: DATA_W] = cap_q[k];
        unique case (off)
          3'd0: rdata = {28'd0, q_empty_in[k], err_q[k],
                         st_q[k] == WAIT, done_q[k]};
          3'd1: rdata = {mask_q[k], 16'd0, q_stat_in[8*k +: 8]};
`ifdef PTP_TSU_REGS_MC_IRQ_EN
          3'd2: rdata = {30'd0, ien_q[k]};
`else
          3'd2: rdata = '0;
`endif
          3'd3: rdata = '0;
          3'd4: rdata = capx[127:96];
          3'd5: rdata = capx[95:64];
          3'd6: rdata = capx[63:32];
          3'd7: rdata = capx[31:0];
          default: rdata = '0;
        endcase
      end
    end
  end

`ifdef PTP_TSU_REGS_MC_IRQ_EN
  always_comb begin
    irq_d = 1'b0;
    for (int k = 0; k < N_CH; k++)
      irq_d = irq_d | (ien_q[k][0] & ~q_empty_in[k])
                    | (ien_q[k][1] & done_q[k]);
  end
  assign irq_out = irq_q;
`else
  assign irq_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      done_q <= '0;
      err_q  <= '0;
      rd_q   <= '0;
      qr_q   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        st_q[k]   <= IDLE;
        cnt_q[k]  <= '0;
        mask_q[k] <= '0;
        cap_q[k]  <= '0;
`ifdef PTP_TSU_REGS_MC_IRQ_EN
        ien_q[k]  <= '0;
`endif
      end
`ifdef PTP_TSU_REGS_MC_IRQ_EN
      irq_q <= 1'b0;
`endif
    end else begin
      if (rd_in)
        dout_q <= rdata;
      done_q <= done_d;
      err_q  <= err_d;
      rd_q   <= rd_d;
      qr_q   <= qr_d;
      for (int k = 0; k < N_CH; k++) begin
        st_q[k]   <= st_d[k];
        cnt_q[k]  <= cnt_d[k];
        mask_q[k] <= mask_d[k];
        cap_q[k]  <= cap_d[k];
`ifdef PTP_TSU_REGS_MC_IRQ_EN
        ien_q[k]  <= ien_d[k];
`endif
      end
`ifdef PTP_TSU_REGS_MC_IRQ_EN
      irq_q <= irq_d;
`endif
    end
  end

  always_comb begin
    q_msgid_mask_out = '0;
    for (int k = 0; k < N_CH; k++)
      q_msgid_mask_out[8*k +: 8] = mask_q[k];
  end

  assign data_out    = dout_q;
  assign q_rd_en_out = rd_q;
  assign q_rst_out   = qr_q;

endmodule

// File: tb/tb_ptp_tsu_regs_mc.sv
// tb_ptp_tsu_regs_mc: scenario bench for ptp_tsu_regs_mc (N_CH=3, RD_LAT=3).
// Bus reads push expectations to a queue; a monitor pops and compares.
module tb_ptp_tsu_regs_mc;
  localparam int N_CH   = 3;
  localparam int DATA_W = 128;
  localparam int RD_LAT = 3;
  localparam int ADDR_W = 8;

  localparam logic [127:0] D1 = 128'hA5A5A5A5_01234567_89ABCDEF_DEADBEEF;
  localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D3 = 128'hCAFEF00D_0BADC0DE_FEEDFACE_12345678;

  logic                   clk;
  logic                   rst;
  logic                   wr_in;
  logic                   rd_in;
  logic [ADDR_W-1:0]      addr_in;
  logic [31:0]            data_in;
  logic [31:0]            data_out;
  logic [N_CH-1:0]        q_rst_out;
  logic [N_CH-1:0]        q_rd_en_out;
  logic [8*N_CH-1:0]      q_msgid_mask_out;
  logic [N_CH-1:0]        q_empty_in;
  logic [8*N_CH-1:0]      q_stat_in;
  logic [DATA_W*N_CH-1:0] q_data_in;
  logic                   irq_out;

  int          total = 0;
  int          bad   = 0;
  int          rden1 = 0;
  logic [31:0] exp_q [$];
  string       nm_q  [$];
  logic [31:0] m_exp;
  string       m_nm;

  ptp_tsu_regs_mc #(
    .N_CH(N_CH), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_in(wr_in), .rd_in(rd_in),
    .addr_in(addr_in), .data_in(data_in), .data_out(data_out),
    .q_rst_out(q_rst_out), .q_rd_en_out(q_rd_en_out),
    .q_msgid_mask_out(q_msgid_mask_out), .q_empty_in(q_empty_in),
    .q_stat_in(q_stat_in), .q_data_in(q_data_in), .irq_out(irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: a read sampled at this edge shows on data_out after it.
  always @(posedge clk) begin
    if (q_rd_en_out[1]) rden1++;
    if (rd_in && rst) begin
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%h exp=none", data_out);
      end else begin
        m_exp = exp_q.pop_front();
        m_nm  = nm_q.pop_front();
        if (data_out !== m_exp) begin
          bad++;
          $display("FAIL %s got=%h exp=%h", m_nm, data_out, m_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    addr_in = a;
    data_in = d;
    wr_in   = 1'b1;
    @(posedge clk);
    #1;
    wr_in = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e,
                    input string nm);
    addr_in = a;
    rd_in   = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    rd_in = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({data_out, q_rst_out, q_rd_en_out, irq_out, q_msgid_mask_out} !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%h/%b/%b/%b/%h exp=0", data_out,
               q_rst_out, q_rd_en_out, irq_out, q_msgid_mask_out);
    end
    rst = 1'b1;
    tick(1);
    rd(8'h00, 32'h8, "reset_ctrl0");
    rd(8'h04, 32'h11, "reset_mask0");
    rd(8'h30, 32'h0, "reset_data1");
  endtask

  task automatic test_pop();
    q_data_in[DATA_W +: DATA_W] = D1;
    q_empty_in[1] = 1'b0;
    wr(8'h20, 32'h1);
    total++;
    if (q_rd_en_out !== 3'b010) begin
      bad++;
      $display("FAIL pop_rden got=%b exp=010", q_rd_en_out);
    end
    rd(8'h20, 32'h2, "pop_busy_a");
    total++;
    if (q_rd_en_out !== 3'b000) begin
      bad++;
      $display("FAIL pop_rden_one got=%b exp=000", q_rd_en_out);
    end
    tick(RD_LAT - 1);
    rd(8'h20, 32'h2, "pop_busy_b");
    rd(8'h20, 32'h1, "pop_done");
    rd(8'h30, D1[127:96], "pop_w0");
    rd(8'h34, D1[95:64], "pop_w1");
    rd(8'h38, D1[63:32], "pop_w2");
    rd(8'h3C, D1[31:0], "pop_w3");
    tick(2);
    total++;
    if (data_out !== D1[31:0]) begin
      bad++;
      $display("FAIL dout_hold got=%h exp=%h", data_out, D1[31:0]);
    end
  endtask

  task automatic test_empty_err();
    wr(8'h00, 32'h1);
    total++;
    if (q_rd_en_out !== 3'b000) begin
      bad++;
      $display("FAIL empty_rden got=%b exp=000", q_rd_en_out);
    end
    rd(8'h00, 32'hC, "empty_err");
    wr(8'h00, 32'h4);
    rd(8'h00, 32'h8, "err_clr");
    wr(8'h00, 32'h5);
    rd(8'h00, 32'hC, "err_set_wins");
    wr(8'h00, 32'h4);
    rd(8'h00, 32'h8, "err_clr2");
  endtask

  task automatic test_back_to_back();
    int base;
    base = rden1;
    q_data_in[DATA_W +: DATA_W] = D2;
    wr(8'h20, 32'h1);
    total++;
    if (q_rd_en_out !== 3'b010) begin
      bad++;
      $display("FAIL b2b_rden got=%b exp=010", q_rd_en_out);
    end
    wr(8'h20, 32'h1);
    total++;
    if (q_rd_en_out !== 3'b000) begin
      bad++;
      $display("FAIL b2b_rden2 got=%b exp=000", q_rd_en_out);
    end
    rd(8'h20, 32'h6, "b2b_busy_err");
    tick(RD_LAT - 1);
    rd(8'h20, 32'h5, "b2b_done_err");
    total++;
    if (rden1 - base !== 1) begin
      bad++;
      $display("FAIL b2b_pulses got=%0d exp=1", rden1 - base);
    end
    rd(8'h30, D2[127:96], "b2b_w0");
    rd(8'h3C, D2[31:0], "b2b_w3");
    wr(8'h20, 32'h4);
    rd(8'h20, 32'h1, "b2b_clr");
  endtask

  task automatic test_qrst();
    wr(8'h20, 32'h3);
    total++;
    if (q_rst_out !== 3'b010 || q_rd_en_out !== 3'b000) begin
      bad++;
      $display("FAIL qrst_pulse got=%b/%b exp=010/000", q_rst_out, q_rd_en_out);
    end
    rd(8'h20, 32'h0, "qrst_ctrl");
    q_data_in[DATA_W +: DATA_W] = D3;
    wr(8'h20, 32'h1);
    wr(8'h20, 32'h2);
    total++;
    if (q_rst_out !== 3'b010) begin
      bad++;
      $display("FAIL qrst_wait got=%b exp=010", q_rst_out);
    end
    tick(RD_LAT + 2);
    rd(8'h20, 32'h0, "qrst_abort");
    rd(8'h30, D2[127:96], "qrst_keep_w0");
    rd(8'h3C, D2[31:0], "qrst_keep_w3");
  endtask

  task automatic test_mask();
    wr(8'h44, 32'h5AFFFFFF);
    total++;
    if (q_msgid_mask_out !== 24'h5A0000) begin
      bad++;
      $display("FAIL mask_out got=%h exp=5a0000", q_msgid_mask_out);
    end
    rd(8'h44, 32'h5A000033, "mask_rd");
    wr(8'h64, 32'hFF000000);
    total++;
    if (q_msgid_mask_out !== 24'h5A0000) begin
      bad++;
      $display("FAIL mask_ch3 got=%h exp=5a0000", q_msgid_mask_out);
    end
    rd(8'h64, 32'h0, "ch3_mask");
    rd(8'h60, 32'h0, "ch3_ctrl");
    rd(8'h4C, 32'h0, "off3");
  endtask

  task automatic test_irq();
`ifdef PTP_TSU_REGS_MC_IRQ_EN
    wr(8'h08, 32'h1);
    tick(1);
    total++;
    if (irq_out !== 1'b0) begin
      bad++;
      $display("FAIL irq_idle got=%b exp=0", irq_out);
    end
    q_empty_in[0] = 1'b0;
    #1;
    total++;
    if (irq_out !== 1'b0) begin
      bad++;
      $display("FAIL irq_early got=%b exp=0", irq_out);
    end
    tick(1);
    total++;
    if (irq_out !== 1'b1) begin
      bad++;
      $display("FAIL irq_set got=%b exp=1", irq_out);
    end
    rd(8'h08, 32'h1, "irqen_rd");
    wr(8'h08, 32'h0);
    tick(1);
    total++;
    if (irq_out !== 1'b0) begin
      bad++;
      $display("FAIL irq_off got=%b exp=0", irq_out);
    end
`else
    wr(8'h08, 32'h3);
    rd(8'h08, 32'h0, "irqen_absent");
    q_empty_in[0] = 1'b0;
    tick(2);
    total++;
    if (irq_out !== 1'b0) begin
      bad++;
      $display("FAIL irq_tied got=%b exp=0", irq_out);
    end
`endif
    q_empty_in[0] = 1'b1;
    tick(1);
  endtask

  task automatic test_reset_mid_wait();
    int base;
    rd(8'h44, 32'h5A000033, "pre_rst_mask");
    wr(8'h20, 32'h1);
    tick(1);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({data_out, q_rst_out, q_rd_en_out, irq_out, q_msgid_mask_out} !== '0) begin
      bad++;
      $display("FAIL rst_async got=%h/%b/%b/%b/%h exp=0", data_out,
               q_rst_out, q_rd_en_out, irq_out, q_msgid_mask_out);
    end
    tick(1);
    rst = 1'b1;
    base = rden1;
    tick(RD_LAT + 2);
    total++;
    if (rden1 !== base) begin
      bad++;
      $display("FAIL rst_no_pop got=%0d exp=%0d", rden1, base);
    end
    rd(8'h20, 32'h0, "rst_ctrl1");
    rd(8'h30, 32'h0, "rst_cap1");
    rd(8'h44, 32'h33, "rst_mask2");
  endtask

  initial begin
    rst        = 1'b1;
    wr_in      = 1'b0;
    rd_in      = 1'b0;
    addr_in    = '0;
    data_in    = '0;
    q_empty_in = 3'b111;
    q_stat_in  = 24'h332211;
    q_data_in  = '0;
    #2;
    rst = 1'b0;
    test_reset();
    test_pop();
    test_empty_err();
    test_back_to_back();
    test_qrst();
    test_mask();
    test_irq();
    test_reset_mid_wait();
    tick(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
